// File: rtl/display_scheduler_pkg.sv
// Shared constants for the display scheduler: display driver modes, baud
// select codes, FSM state encodings, round-robin source indices and the
// round-robin helper functions.
package display_scheduler_pkg;

    // Display driver modes
    localparam logic BAUDRATE_MODE = 1'b0;
    localparam logic DATA_MODE     = 1'b1;

    // Baud select codes as seen on baud_sel (code 3 is passed through and blanked downstream)
    localparam logic [1:0] SEL_9600   = 2'd0;
    localparam logic [1:0] SEL_57600  = 2'd1;
    localparam logic [1:0] SEL_115200 = 2'd2;

    // FSM state encodings
    localparam logic [1:0] DSCH_IDLE = 2'd0;
    localparam logic [1:0] DSCH_BAUD = 2'd1;
    localparam logic [1:0] DSCH_TX   = 2'd2;
    localparam logic [1:0] DSCH_RX   = 2'd3;

    // Round-robin source indices (also bit positions in the pending vector)
    localparam logic [1:0] SRC_BAUD = 2'd0;
    localparam logic [1:0] SRC_TX   = 2'd1;
    localparam logic [1:0] SRC_RX   = 2'd2;

    // Source that follows src in the BAUD -> TX -> RX -> BAUD ring
    function automatic logic [1:0] rr_next(input logic [1:0] src);
        logic [1:0] nxt;
        case (src)
            SRC_BAUD: nxt = SRC_TX;
            SRC_TX:   nxt = SRC_RX;
            default:  nxt = SRC_BAUD;
        endcase
        return nxt;
    endfunction

    // First pending source at or after ptr; bit 2 = found, bits 1:0 = source
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] pend);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        idx = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!res[2] && pend[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
            idx = rr_next(idx);
        end
        return res;
    endfunction

endpackage

// File: rtl/disp_rx_fifo.sv
// Small synchronous FIFO holding received bytes waiting for display time.
// Only built when DISP_RX_FIFO_EN is defined. The caller gates push so
// that a push into a full FIFO only happens together with a pop.
`ifdef DISP_RX_FIFO_EN
module disp_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         src_clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          wr_en_s;
    logic          rd_en_s;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign rd_data = mem_r[rd_ptr_r];
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || rd_en_s);

    // Storage, pointers and occupancy count
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
`endif

// File: rtl/display_scheduler.sv
// Shares one 7-digit BCD display between the baud selection, TX bytes and
// RX bytes. Requests are latched, served round-robin and each shown for
// HOLD_CYCLES cycles; with nothing pending the current baud selection is
// shown. Build option DISP_RX_FIFO_EN replaces the single RX slot with a
// FIFO_DEPTH-entry queue (disp_rx_fifo).
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
`ifdef DISP_RX_FIFO_EN
    ,
    parameter int FIFO_DEPTH  = 4
`endif
) (
    input  logic       src_clk,
    input  logic       rst_n,
    input  logic [1:0] baud_sel,
    input  logic       tx_vld,
    input  logic [7:0] tx_data,
    input  logic       rx_vld,
    input  logic [7:0] rx_data,
    output logic       disp_mode,
    output logic [7:0] disp_msg,
    output logic       busy,
    output logic       drop
);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       baud_q_r;
    logic             baud_init_r;
    logic             pend_baud_r;
    logic             pend_tx_r;
    logic [7:0]       tx_slot_r;
    // Next source to try first; starts at BAUD and moves past each grant
    logic [1:0]       rr_ptr_r;
    logic             disp_mode_r;
    logic [7:0]       disp_msg_r;
    logic             busy_r;
    logic             drop_r;

    logic             baud_chg_s;
    logic             hold_done_s;
    logic             arb_en_s;
    logic [2:0]       pick_s;
    logic             grant_vld_s;
    logic [1:0]       grant_src_s;
    logic             grant_baud_s;
    logic             grant_tx_s;
    logic             grant_rx_s;
    logic             drop_tx_s;
    logic             drop_rx_s;
    logic             pend_rx_s;
    logic [7:0]       rx_head_s;

    // The first edge after reset only seeds baud_q, so it never raises a request
    assign baud_chg_s = baud_init_r && (baud_sel != baud_q_r);
    // A vld that lands in the slot's consume cycle is not a loss
    assign drop_tx_s  = tx_vld && pend_tx_r && !grant_tx_s;

`ifdef DISP_RX_FIFO_EN
    logic fifo_full_s;
    logic fifo_empty_s;

    disp_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_rx_fifo (
        .src_clk (src_clk),
        .rst_n   (rst_n),
        .push    (rx_vld && (!fifo_full_s || grant_rx_s)),
        .wr_data (rx_data),
        .pop     (grant_rx_s),
        .rd_data (rx_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign pend_rx_s = !fifo_empty_s;
    assign drop_rx_s = rx_vld && fifo_full_s && !grant_rx_s;
`else
    logic       pend_rx_r;
    logic [7:0] rx_slot_r;

    // Single RX slot: a new byte overwrites any byte still waiting
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_rx_r <= 1'b0;
            rx_slot_r <= 8'h00;
        end else begin
            pend_rx_r <= (pend_rx_r && !grant_rx_s) || rx_vld;
            if (rx_vld) begin
                rx_slot_r <= rx_data;
            end
        end
    end

    assign pend_rx_s = pend_rx_r;
    assign rx_head_s = rx_slot_r;
    assign drop_rx_s = rx_vld && pend_rx_r && !grant_rx_s;
`endif

    // Arbitration and next-state: grant from IDLE or at the end of a hold
    always_comb begin
        hold_done_s  = (state_r != DSCH_IDLE) && (cnt_r == CNT_W'(HOLD_CYCLES - 1));
        arb_en_s     = (state_r == DSCH_IDLE) || hold_done_s;
        pick_s       = rr_pick(rr_ptr_r, {pend_rx_s, pend_tx_r, pend_baud_r});
        grant_vld_s  = arb_en_s && pick_s[2];
        grant_src_s  = pick_s[1:0];
        grant_baud_s = grant_vld_s && (grant_src_s == SRC_BAUD);
        grant_tx_s   = grant_vld_s && (grant_src_s == SRC_TX);
        grant_rx_s   = grant_vld_s && (grant_src_s == SRC_RX);
        state_nxt_s  = state_r;
        if (grant_vld_s) begin
            case (grant_src_s)
                SRC_BAUD: state_nxt_s = DSCH_BAUD;
                SRC_TX:   state_nxt_s = DSCH_TX;
                SRC_RX:   state_nxt_s = DSCH_RX;
                default:  state_nxt_s = DSCH_IDLE;
            endcase
        end else if (hold_done_s) begin
            state_nxt_s = DSCH_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Request capture, FSM state, hold counter and round-robin pointer
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= DSCH_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            baud_q_r    <= 2'b00;
            baud_init_r <= 1'b0;
            pend_baud_r <= 1'b0;
            pend_tx_r   <= 1'b0;
            tx_slot_r   <= 8'h00;
            rr_ptr_r    <= SRC_BAUD;
        end else begin
            baud_init_r <= 1'b1;
            baud_q_r    <= baud_sel;
            pend_baud_r <= (pend_baud_r && !grant_baud_s) || baud_chg_s;
            pend_tx_r   <= (pend_tx_r && !grant_tx_s) || tx_vld;
            if (tx_vld) begin
                tx_slot_r <= tx_data;
            end
            state_r <= state_nxt_s;
            if (grant_vld_s) begin
                cnt_r    <= {CNT_W{1'b0}};
                rr_ptr_r <= rr_next(grant_src_s);
            end else if (state_r != DSCH_IDLE) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // Registered display outputs, computed from the state being entered
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_mode_r <= BAUDRATE_MODE;
            disp_msg_r  <= 8'h00;
            busy_r      <= 1'b0;
            drop_r      <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != DSCH_IDLE);
            drop_r <= drop_tx_s || drop_rx_s;
            case (state_nxt_s)
                DSCH_TX: begin
                    disp_mode_r <= DATA_MODE;
                    disp_msg_r  <= grant_tx_s ? tx_slot_r : disp_msg_r;
                end
                DSCH_RX: begin
                    disp_mode_r <= DATA_MODE;
                    disp_msg_r  <= grant_rx_s ? rx_head_s : disp_msg_r;
                end
                default: begin
                    // IDLE and SHOW_BAUD both track the freshly sampled selection
                    disp_mode_r <= BAUDRATE_MODE;
                    disp_msg_r  <= {6'b000000, baud_sel};
                end
            endcase
        end
    end

    assign disp_mode = disp_mode_r;
    assign disp_msg  = disp_msg_r;
    assign busy      = busy_r;
    assign drop      = drop_r;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler with a short hold time.
// Expected display contents are queued when stimulus is driven and popped
// when the corresponding hold window is observed.
module tb_display_scheduler;

    localparam int   HOLD   = 4;
    localparam logic M_BAUD = 1'b0;
    localparam logic M_DATA = 1'b1;

    logic       src_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [1:0] baud_sel = 2'd1;
    logic       tx_vld  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_vld  = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       disp_mode;
    logic [7:0] disp_msg;
    logic       busy;
    logic       drop;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_cur;
    logic [8:0] exp_drop;

    always #5 src_clk = ~src_clk;

    display_scheduler #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (3)
    ) dut (
        .src_clk   (src_clk),
        .rst_n     (rst_n),
        .baud_sel  (baud_sel),
        .tx_vld    (tx_vld),
        .tx_data   (tx_data),
        .rx_vld    (rx_vld),
        .rx_data   (rx_data),
        .disp_mode (disp_mode),
        .disp_msg  (disp_msg),
        .busy      (busy),
        .drop      (drop)
    );

    task automatic cmp(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge src_clk);
    endtask

    task automatic check_idle(input string tag, input logic [1:0] b);
        cmp({tag, "_disp"}, {disp_mode, disp_msg}, {M_BAUD, 6'b000000, b});
        cmp({tag, "_busy"}, {8'h00, busy}, 9'h000);
    endtask

    // Pops one expected display value and checks it for a full hold window
    task automatic show_hold(input string tag);
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb_empty observed=none expected=queued entry", tag);
            e = 9'h000;
        end else begin
            e = exp_q.pop_front();
        end
        for (int i = 0; i < HOLD; i++) begin
            cmp({tag, "_disp"}, {disp_mode, disp_msg}, e);
            cmp({tag, "_busy"}, {8'h00, busy}, 9'h001);
            cmp({tag, "_drop"}, {8'h00, drop}, 9'h000);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while rst_n is low
        #1;
        cmp("rst_disp", {disp_mode, disp_msg}, {M_BAUD, 8'h00});
        cmp("rst_busy", {8'h00, busy}, 9'h000);
        cmp("rst_drop", {8'h00, drop}, 9'h000);
        step();
        step();
        rst_n = 1'b1;
        // Idle after release: baud 1 shown, no SHOW_BAUD entered
        for (int i = 0; i < 6; i++) begin
            step();
            check_idle("idle_b1", 2'd1);
        end

        // Single TX byte from IDLE
        tx_vld  = 1'b1;
        tx_data = 8'h41;
        exp_q.push_back({M_DATA, 8'h41});
        step();
        tx_vld = 1'b0;
        check_idle("tx_lat", 2'd1);
        step();
        show_hold("tx41");
        check_idle("tx_done", 2'd1);

        // Reset so the round-robin pointer starts at BAUD again
        rst_n = 1'b0;
        #1;
        cmp("rst2_disp", {disp_mode, disp_msg}, {M_BAUD, 8'h00});
        step();
        rst_n = 1'b1;
        step();
        check_idle("rel2", 2'd1);

        // All three sources in the same cycle
        baud_sel = 2'd2;
        tx_vld   = 1'b1;
        tx_data  = 8'h31;
        rx_vld   = 1'b1;
        rx_data  = 8'h5A;
        exp_q.push_back({M_BAUD, 8'h02});
        exp_q.push_back({M_DATA, 8'h31});
        exp_q.push_back({M_DATA, 8'h5A});
        step();
        tx_vld = 1'b0;
        rx_vld = 1'b0;
        check_idle("sim_lat", 2'd2);
        cmp("sim_drop", {8'h00, drop}, 9'h000);
        step();
        show_hold("sim_baud");
        show_hold("sim_tx");
        show_hold("sim_rx");
        check_idle("sim_done", 2'd2);

        // Two RX strobes during a TX hold
        tx_vld  = 1'b1;
        tx_data = 8'h77;
        exp_q.push_back({M_DATA, 8'h77});
        step();
        tx_vld = 1'b0;
        step();
        exp_cur = exp_q.pop_front();
        cmp("ov_c0_disp", {disp_mode, disp_msg}, exp_cur);
        rx_vld  = 1'b1;
        rx_data = 8'h10;
        exp_q.push_back({M_DATA, 8'h10});
        step();
        cmp("ov_c1_disp", {disp_mode, disp_msg}, exp_cur);
        cmp("ov_c1_drop", {8'h00, drop}, 9'h000);
        rx_data = 8'h20;
`ifdef DISP_RX_FIFO_EN
        exp_q.push_back({M_DATA, 8'h20});
        exp_drop = 9'h000;
`else
        void'(exp_q.pop_back());
        exp_q.push_back({M_DATA, 8'h20});
        exp_drop = 9'h001;
`endif
        step();
        rx_vld = 1'b0;
        cmp("ov_c2_disp", {disp_mode, disp_msg}, exp_cur);
        cmp("ov_c2_drop", {8'h00, drop}, exp_drop);
        step();
        cmp("ov_c3_disp", {disp_mode, disp_msg}, exp_cur);
        cmp("ov_c3_drop", {8'h00, drop}, 9'h000);
        cmp("ov_c3_busy", {8'h00, busy}, 9'h001);
        step();
        show_hold("ov_rx_a");
`ifdef DISP_RX_FIFO_EN
        show_hold("ov_rx_b");
`endif
        check_idle("ov_done", 2'd2);

`ifdef DISP_RX_FIFO_EN
        // Five RX strobes around a TX hold: the fifth finds the FIFO full
        tx_vld  = 1'b1;
        tx_data = 8'h88;
        rx_vld  = 1'b1;
        rx_data = 8'hB1;
        exp_q.push_back({M_DATA, 8'h88});
        exp_q.push_back({M_DATA, 8'hB1});
        step();
        tx_vld = 1'b0;
        exp_cur = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'hB2 + 8'(i);
            if (i < 3) begin
                exp_q.push_back({M_DATA, rx_data});
            end
            step();
            cmp("ff_tx_disp", {disp_mode, disp_msg}, exp_cur);
            cmp("ff_drop", {8'h00, drop}, (i == 3) ? 9'h001 : 9'h000);
        end
        rx_vld = 1'b0;
        step();
        show_hold("ff_rx1");
        show_hold("ff_rx2");
        show_hold("ff_rx3");
        show_hold("ff_rx4");
        check_idle("ff_done", 2'd2);
`endif

        // Reset in the middle of an RX hold with a TX byte pending
        rx_vld  = 1'b1;
        rx_data = 8'hAA;
        exp_q.push_back({M_DATA, 8'hAA});
        step();
        rx_vld = 1'b0;
        step();
        exp_cur = exp_q.pop_front();
        cmp("mr_c0_disp", {disp_mode, disp_msg}, exp_cur);
        cmp("mr_c0_busy", {8'h00, busy}, 9'h001);
        tx_vld  = 1'b1;
        tx_data = 8'h99;
        step();
        tx_vld = 1'b0;
        cmp("mr_c1_disp", {disp_mode, disp_msg}, exp_cur);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("mr_rst_disp", {disp_mode, disp_msg}, {M_BAUD, 8'h00});
        cmp("mr_rst_busy", {8'h00, busy}, 9'h000);
        cmp("mr_rst_drop", {8'h00, drop}, 9'h000);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3 * HOLD; i++) begin
            step();
            check_idle("mr_post", 2'd2);
        end

        // Unused select code is shown as-is
        baud_sel = 2'd3;
        exp_q.push_back({M_BAUD, 8'h03});
        step();
        check_idle("b3_lat", 2'd3);
        step();
        show_hold("b3");
        check_idle("b3_done", 2'd3);

        cmp("sb_left", 9'(exp_q.size()), 9'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
